// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the three-port DRAM round-robin arbiter.
package dram_arb_pkg;

   localparam int unsigned NPORTS = 3;
   localparam int unsigned IDX_W  = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

   typedef enum logic {
      SLOT_RD = 1'b0,
      SLOT_WR = 1'b1
   } slot_kind_e;

   // (base + step) mod NPORTS for base < NPORTS and step <= NPORTS
   function automatic logic [IDX_W-1:0] rr_offset(input logic [IDX_W-1:0] base,
                                                  input logic [IDX_W-1:0] step);
      logic [IDX_W:0] sum;
      sum = {1'b0, base} + {1'b0, step};
      if (sum >= (IDX_W+1)'(NPORTS)) begin
         sum = sum - (IDX_W+1)'(NPORTS);
      end
      return sum[IDX_W-1:0];
   endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin selector: first pending port after last_grant.
module rr_pick3
   import dram_arb_pkg::*;
(
   input  logic [NPORTS-1:0] pending_i,
   input  logic [IDX_W-1:0]  last_grant_i,
   output logic [IDX_W-1:0]  grant_c_o,
   output logic              grant_valid_c_o
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      grant_c_o       = '0;
      grant_valid_c_o = 1'b0;
      cand            = '0;
      for (int unsigned k = 1; k <= NPORTS; k++) begin
         cand = rr_offset(last_grant_i, IDX_W'(k));
         if (!grant_valid_c_o && pending_i[cand]) begin
            grant_c_o       = cand;
            grant_valid_c_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dram_rr_arbiter.sv
// Three-requester round-robin arbiter in front of a single DRAM controller port,
// with per-port pending slots and a WAIT-state watchdog.
module dram_rr_arbiter
   import dram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 24,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NPORTS*ADDR_W-1:0] req_addr_i,
   input  logic [NPORTS*DATA_W-1:0] req_wdata_i,
   input  logic [NPORTS-1:0]        req_read_i,
   input  logic [NPORTS-1:0]        req_write_i,
   output logic [NPORTS-1:0]        port_busy_o,
   output logic [NPORTS*DATA_W-1:0] rdata_o,
   output logic [NPORTS-1:0]        data_valid_o,
   output logic [NPORTS-1:0]        write_complete_o,
   output logic [NPORTS-1:0]        error_o,
   output logic [ADDR_W-1:0]        dram_addr_o,
   output logic [DATA_W-1:0]        dram_data_in_o,
   output logic                     dram_req_read_o,
   output logic                     dram_req_write_o,
   input  logic [DATA_W-1:0]        dram_data_out_i,
   input  logic                     dram_data_out_valid_i,
   input  logic                     dram_write_complete_i
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   state_e                          state_q, state_d;
   logic [NPORTS-1:0]               busy_q, busy_d;
   slot_kind_e                      kind_q [NPORTS];
   slot_kind_e                      kind_d [NPORTS];
   logic [NPORTS-1:0][ADDR_W-1:0]   addr_q, addr_d;
   logic [NPORTS-1:0][DATA_W-1:0]   wdata_q, wdata_d;
   logic [NPORTS-1:0][DATA_W-1:0]   rdata_q, rdata_d;
   logic [NPORTS-1:0]               dv_q, dv_d;
   logic [NPORTS-1:0]               wc_q, wc_d;
   logic [NPORTS-1:0]               err_q, err_d;
   logic                            rd_stb_q, rd_stb_d;
   logic                            wr_stb_q, wr_stb_d;
   logic [ADDR_W-1:0]               dram_addr_q, dram_addr_d;
   logic [DATA_W-1:0]               dram_data_q, dram_data_d;
   logic [IDX_W-1:0]                gnt_q, gnt_d;
   logic                            gnt_wr_q, gnt_wr_d;
   logic [IDX_W-1:0]                last_q, last_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;

   logic [IDX_W-1:0]                pick_idx_c;
   logic                            pick_valid_c;
   logic                            in_wait_c;
   logic                            rd_done_c;
   logic                            wr_done_c;
   logic                            timeout_c;
   logic [CNT_W-1:0]                cnt_inc_c;

   rr_pick3 u_pick (
      .pending_i       (busy_q),
      .last_grant_i    (last_q),
      .grant_c_o       (pick_idx_c),
      .grant_valid_c_o (pick_valid_c)
   );

   // A matching completion in the final WAIT cycle beats the watchdog
   assign in_wait_c = (state_q == ST_WAIT);
   assign rd_done_c = in_wait_c && !gnt_wr_q && dram_data_out_valid_i;
   assign wr_done_c = in_wait_c &&  gnt_wr_q && dram_write_complete_i;
   assign cnt_inc_c = cnt_q + CNT_W'(1);
   assign timeout_c = in_wait_c && !rd_done_c && !wr_done_c && (cnt_inc_c == CNT_W'(TIMEOUT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (pick_valid_c) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT:  if (rd_done_c || wr_done_c || timeout_c) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_d      = busy_q;
      kind_d      = kind_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      dv_d        = '0;
      wc_d        = '0;
      err_d       = '0;
      rd_stb_d    = 1'b0;
      wr_stb_d    = 1'b0;
      dram_addr_d = dram_addr_q;
      dram_data_d = dram_data_q;
      gnt_d       = gnt_q;
      gnt_wr_d    = gnt_wr_q;
      last_d      = last_q;
      cnt_d       = cnt_q;

      // Idle ports accept a request; a write wins over a simultaneous read
      for (int p = 0; p < NPORTS; p++) begin
         if (!busy_q[p] && (req_write_i[p] || req_read_i[p])) begin
            busy_d[p]  = 1'b1;
            kind_d[p]  = req_write_i[p] ? SLOT_WR : SLOT_RD;
            addr_d[p]  = req_addr_i[p*ADDR_W +: ADDR_W];
            wdata_d[p] = req_wdata_i[p*DATA_W +: DATA_W];
         end
      end

      unique case (state_q)
         ST_IDLE: begin
            if (pick_valid_c) begin
               gnt_d       = pick_idx_c;
               gnt_wr_d    = (kind_q[pick_idx_c] == SLOT_WR);
               dram_addr_d = addr_q[pick_idx_c];
               dram_data_d = wdata_q[pick_idx_c];
               rd_stb_d    = (kind_q[pick_idx_c] == SLOT_RD);
               wr_stb_d    = (kind_q[pick_idx_c] == SLOT_WR);
            end
         end
         ST_ISSUE: begin
            cnt_d = '0;
         end
         ST_WAIT: begin
            cnt_d = cnt_inc_c;
            if (rd_done_c || wr_done_c || timeout_c) begin
               busy_d[gnt_q] = 1'b0;
               last_d        = gnt_q;
            end
            if (rd_done_c) begin
               rdata_d[gnt_q] = dram_data_out_i;
               dv_d[gnt_q]    = 1'b1;
            end else if (wr_done_c) begin
               wc_d[gnt_q] = 1'b1;
            end else if (timeout_c) begin
               err_d[gnt_q] = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q      <= '0;
         for (int p = 0; p < NPORTS; p++) kind_q[p] <= SLOT_RD;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         dv_q        <= '0;
         wc_q        <= '0;
         err_q       <= '0;
         rd_stb_q    <= 1'b0;
         wr_stb_q    <= 1'b0;
         dram_addr_q <= '0;
         dram_data_q <= '0;
         gnt_q       <= '0;
         gnt_wr_q    <= 1'b0;
         last_q      <= IDX_W'(NPORTS - 1);
         cnt_q       <= '0;
      end else begin
         busy_q      <= busy_d;
         kind_q      <= kind_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         dv_q        <= dv_d;
         wc_q        <= wc_d;
         err_q       <= err_d;
         rd_stb_q    <= rd_stb_d;
         wr_stb_q    <= wr_stb_d;
         dram_addr_q <= dram_addr_d;
         dram_data_q <= dram_data_d;
         gnt_q       <= gnt_d;
         gnt_wr_q    <= gnt_wr_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
      end
   end

   assign port_busy_o      = busy_q;
   assign rdata_o          = rdata_q;
   assign data_valid_o     = dv_q;
   assign write_complete_o = wc_q;
   assign error_o          = err_q;
   assign dram_addr_o      = dram_addr_q;
   assign dram_data_in_o   = dram_data_q;
   assign dram_req_read_o  = rd_stb_q;
   assign dram_req_write_o = wr_stb_q;

endmodule

// File: doc/dram_rr_arbiter.md
Name: dram_rr_arbiter

Overview:
Three-requester round-robin arbiter for the single DRAM controller port. It replaces fixed-priority sharing so that no requester can starve another.
- Each requester issues single-cycle read/write pulses. The block latches them into per-port pending slots and sequences one DRAM transaction at a time.
- It routes the completion back to the owning port.
- A watchdog aborts any transaction the DRAM never completes.

Parameters:
ADDR_W, 24, DRAM word address width
DATA_W, 32, DRAM data width
TIMEOUT, 255, max cycles in WAIT before abort (must be >= 1; counter width = clog2(TIMEOUT+1))

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_addr  in  3*ADDR_W  per-port address, port p at [p*ADDR_W +: ADDR_W]
req_wdata  in  3*DATA_W  per-port write data
req_read  in  3  per-port read request pulse
req_write  in  3  per-port write request pulse
port_busy  out  3  port has a pending or in-flight request
rdata  out  3*DATA_W  per-port read data, held until that port's next read completes
data_valid  out  3  one-cycle read-done pulse
write_complete  out  3  one-cycle write-done pulse
error  out  3  one-cycle timeout-abort pulse
dram_addr  out  ADDR_W  address to DRAM controller
dram_data_in  out  DATA_W  write data to DRAM controller
dram_req_read  out  1  one-cycle read strobe
dram_req_write  out  1  one-cycle write strobe
dram_data_out  in  DATA_W  read data from controller
dram_data_out_valid  in  1  read data valid pulse
dram_write_complete  in  1  write done pulse

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state IDLE; pending slots cleared; last_grant=2, so port 0 wins first. Reset mid-transaction drops all pending and in-flight work with no completion or error pulses, and deasserts dram strobes immediately.
- Capture, at every edge, for each port p with port_busy[p]=0:
  - req_write[p] latches a write (addr, wdata).
  - Otherwise req_read[p] latches a read (addr).
  - Read and write asserted together: the write is latched and the read is discarded.
  - port_busy[p] goes high at that edge.
  - Pulses while port_busy[p]=1 are ignored, including at the edge where p completes.
- FSM states IDLE, ISSUE, WAIT:
  - IDLE: if any slot is pending, grant the first pending port scanning last_grant+1, +2, +3 (mod 3). Load dram_addr/dram_data_in from that slot, register the matching strobe high, go to ISSUE. A slot latched at edge E can be granted at edge E+1 at the earliest.
  - ISSUE (one cycle): the strobe is visible for exactly this cycle. At the next edge drop the strobe, clear the timeout counter, go to WAIT.
  - WAIT, read grant: on dram_data_out_valid, copy dram_data_out to rdata[g], pulse data_valid[g] the following cycle, clear slot g and port_busy[g], set last_grant=g, go to IDLE.
  - WAIT, write grant: on dram_write_complete, pulse write_complete[g], clear slot g and busy, set last_grant=g, go to IDLE.
  - WAIT, wrong-type completion (e.g. write_complete during a read): ignored.
  - WAIT, timeout: counter increments each WAIT cycle. When it equals TIMEOUT with no completion, pulse error[g], clear slot g and busy, set last_grant=g, go to IDLE. A completion arriving in the same cycle as the timeout wins, so no error is raised.
- Completions in IDLE/ISSUE are ignored.
- dram_addr/dram_data_in hold their last value outside ISSUE.
- At most one of dram_req_read/dram_req_write is high at any time.
- Minimum turnaround: two cycles from completion to the next strobe (IDLE grant, then ISSUE).

Decomposition:
- Shared package dram_arb_pkg: state encoding (IDLE/ISSUE/WAIT), NPORTS=3, and a slot-type constant (RD/WR).
- One sub-module, rr_pick3: combinational round-robin selector. Inputs: pending[2:0] and last_grant. Outputs: grant index and grant_valid.
- The FSM, slots, and watchdog live in the top module.

Test Plan:
- Reset, then pulse req_read[0] with addr 0x000100; DRAM returns 0xDEADBEEF 3 cycles after the strobe -> one dram_req_read cycle with dram_addr=0x000100, then data_valid[0] for one cycle with rdata[0]=0xDEADBEEF, and port_busy[0] clears.
- All three ports pulse reads at the same edge with immediate DRAM responses -> grant order 0, 1, 2. Port 0 then pulses again -> next grant is 0 only after 2 is served.
- req_write[1] with addr 0x00ABCD, data 0x12345678, and req_read[1] at the same edge -> only dram_req_write with dram_data_in=0x12345678; write_complete[1] pulses once.
- TIMEOUT=4, read on port 2, DRAM silent -> error[2] pulses once after 4 WAIT cycles, no data_valid, and the next pending port is granted.
- Second req_read[0] pulse while port 0 is in WAIT -> ignored; exactly one dram strobe and one data_valid[0].
- rst_n low during WAIT of a write on port 1 -> strobes and busy go to 0 immediately; a later dram_write_complete produces no write_complete pulse.
